// File: rtl/dcache_writeback_buffer_if.sv
`default_nettype none
// =============================================================================
// Module   : dcache_writeback_buffer_if
// Brief    : Push, lookup and memory-write signals of the dcache writeback buffer.
// Revision : 1.0 - initial release
// =============================================================================
interface dcache_writeback_buffer_if #(
    parameter int DEPTH      = 2,
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 34
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                  push_valid_i;
    logic                  push_ready_o;
    logic [ADDR_WIDTH-1:0] push_addr_i;
    logic [LINE_WIDTH-1:0] push_data_i;
    logic [ADDR_WIDTH-1:0] lookup_addr_i;
    logic                  lookup_hit_o;
    logic [LINE_WIDTH-1:0] lookup_data_o;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [LINE_WIDTH-1:0] mem_data_o;
    logic [2:0]            mem_size_o;
    logic                  mem_we_o;
    logic                  mem_ack_i;
    logic                  mem_done_i;
    logic [c_CNT_W-1:0]    count_o;
    logic                  empty_o;

    // The master is the environment: the cache pushes/looks up, memory answers.
    modport master (
        output push_valid_i, push_addr_i, push_data_i, lookup_addr_i,
               mem_ack_i, mem_done_i,
        input  push_ready_o, lookup_hit_o, lookup_data_o, mem_req_o,
               mem_addr_o, mem_data_o, mem_size_o, mem_we_o, count_o, empty_o
    );

    modport slave (
        input  push_valid_i, push_addr_i, push_data_i, lookup_addr_i,
               mem_ack_i, mem_done_i,
        output push_ready_o, lookup_hit_o, lookup_data_o, mem_req_o,
               mem_addr_o, mem_data_o, mem_size_o, mem_we_o, count_o, empty_o
    );
endinterface
`default_nettype wire

// File: rtl/dcache_writeback_buffer.sv
`default_nettype none
// =============================================================================
// Module   : dcache_writeback_buffer
// Brief    : In-order buffer for evicted dirty lines, drained over req/ack/done,
//            with line lookup. Macro DCACHE_WBUF_FWD_EN enables data forwarding.
// Revision : 1.0 - initial release
// =============================================================================
module dcache_writeback_buffer #(
    parameter int DEPTH      = 2,
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 34
) (
    input  logic clk_i,
    input  logic rst_i,
    dcache_writeback_buffer_if.slave bus
);
    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_TAG_W  = ADDR_WIDTH - OFFSET_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [c_PTR_W-1:0]   head_q, head_d;
    logic [c_PTR_W-1:0]   tail_q, tail_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic                 mem_req_q, mem_req_d;
    logic [c_TAG_W-1:0]   tag_q  [DEPTH];
    logic [c_TAG_W-1:0]   tag_d  [DEPTH];
    logic [LINE_WIDTH-1:0] data_q [DEPTH];
    logic [LINE_WIDTH-1:0] data_d [DEPTH];

    logic                 push;
    logic                 pop;
    logic                 push_ready;
    logic                 hit;
    logic [c_PTR_W-1:0]   fwd_idx;
    logic [c_PTR_W-1:0]   idx;
    logic [c_TAG_W-1:0]   lookup_tag;
    logic                 unused_ok;

    assign push_ready = (count_q != c_FULL);
    assign lookup_tag = bus.lookup_addr_i[ADDR_WIDTH-1:OFFSET_W];

    always_comb begin
        push      = bus.push_valid_i && push_ready;
        // The head entry is only released once memory reports completion.
        pop       = (state_q == S_WAIT_DONE) && bus.mem_done_i;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        state_d   = state_q;

        if (push) tail_d = tail_q + c_PTR_W'(1);
        if (pop)  head_d = head_q + c_PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.mem_ack_i) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.mem_done_i) state_d = (count_d != '0) ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        mem_req_d = (state_d == S_REQ);
    end

    always_comb begin
        tag_d  = tag_q;
        data_d = data_q;
        if (push) begin
            tag_d[tail_q]  = bus.push_addr_i[ADDR_WIDTH-1:OFFSET_W];
            data_d[tail_q] = bus.push_data_i;
        end
    end

    // Scan oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        hit     = 1'b0;
        fwd_idx = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + c_PTR_W'(i);
            if ((c_CNT_W'(i) < count_q) && (tag_q[idx] == lookup_tag)) begin
                hit     = 1'b1;
                fwd_idx = idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            mem_req_q <= mem_req_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.push_ready_o = push_ready;
    assign bus.lookup_hit_o = hit;
    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = {tag_q[head_q], {OFFSET_W{1'b0}}};
    assign bus.mem_data_o   = data_q[head_q];
    assign bus.mem_size_o   = 3'b111;
    assign bus.mem_we_o     = 1'b1;
    assign bus.count_o      = count_q;
    assign bus.empty_o      = (count_q == '0);

`ifdef DCACHE_WBUF_FWD_EN
    assign bus.lookup_data_o = hit ? data_q[fwd_idx] : '0;
    assign unused_ok = ^{bus.push_addr_i[OFFSET_W-1:0], bus.lookup_addr_i[OFFSET_W-1:0]};
`else
    assign bus.lookup_data_o = '0;
    assign unused_ok = ^{bus.push_addr_i[OFFSET_W-1:0], bus.lookup_addr_i[OFFSET_W-1:0],
                         fwd_idx};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_writeback_buffer.sv
`default_nettype none
// =============================================================================
// Module   : tb_dcache_writeback_buffer
// Brief    : Directed bench; memory requests are checked by a scoreboard monitor.
// Revision : 1.0 - initial release
// =============================================================================
module tb_dcache_writeback_buffer;
    localparam int DEPTH      = 2;
    localparam int LINE_WIDTH = 128;
    localparam int ADDR_WIDTH = 34;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    req_t exp_q[$];
    req_t mon_e;
    bit   req_seen = 1'b0;

    dcache_writeback_buffer_if #(.DEPTH(DEPTH), .LINE_WIDTH(LINE_WIDTH),
                                 .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    dcache_writeback_buffer #(.DEPTH(DEPTH), .LINE_WIDTH(LINE_WIDTH),
                              .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [LINE_WIDTH-1:0] act,
                       input logic [LINE_WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: each new memory request is matched against the oldest expected line.
    always @(negedge clk) begin
        if (rst || !bus.mem_req_o) begin
            req_seen = 1'b0;
        end else if (!req_seen) begin
            req_seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_req: got addr %h want no request", bus.mem_addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                cmp("mem_addr", LINE_WIDTH'(bus.mem_addr_o), LINE_WIDTH'(mon_e.addr));
                cmp("mem_data", bus.mem_data_o, mon_e.data);
                cmp("mem_size", LINE_WIDTH'(bus.mem_size_o), LINE_WIDTH'(3'b111));
                cmp("mem_we",   LINE_WIDTH'(bus.mem_we_o), LINE_WIDTH'(1'b1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [ADDR_WIDTH-1:0] a, input logic [LINE_WIDTH-1:0] d);
        bus.push_valid_i = 1'b1;
        bus.push_addr_i  = a;
        bus.push_data_i  = d;
        exp_q.push_back('{addr: {a[ADDR_WIDTH-1:4], 4'b0000}, data: d});
        tick();
        bus.push_valid_i = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req_o) break;
            tick();
        end
        if (!bus.mem_req_o) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: got mem_req_o 0 want 1 within 20 cycles");
        end
    endtask

    task automatic ack_req();
        wait_req();
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
    endtask

    task automatic finish_done();
        bus.mem_done_i = 1'b1;
        tick();
        bus.mem_done_i = 1'b0;
    endtask

    localparam logic [ADDR_WIDTH-1:0] A1 = 34'h0_8000_1234;
    localparam logic [ADDR_WIDTH-1:0] AL = 34'h1_0000_0040;
    localparam logic [LINE_WIDTH-1:0] DAA = {16{8'hAA}};
    localparam logic [LINE_WIDTH-1:0] DBB = {16{8'hBB}};
`ifdef DCACHE_WBUF_FWD_EN
    localparam logic [LINE_WIDTH-1:0] FWD_BB = DBB;
`else
    localparam logic [LINE_WIDTH-1:0] FWD_BB = '0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push_valid_i  = 1'b0;
        bus.push_addr_i   = '0;
        bus.push_data_i   = '0;
        bus.lookup_addr_i = A1;
        bus.mem_ack_i     = 1'b0;
        bus.mem_done_i    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        cmp("rst_count", LINE_WIDTH'(bus.count_o), 0);
        cmp("rst_empty", LINE_WIDTH'(bus.empty_o), 1);
        cmp("rst_req",   LINE_WIDTH'(bus.mem_req_o), 0);
        cmp("rst_hit",   LINE_WIDTH'(bus.lookup_hit_o), 0);
        cmp("rst_ready", LINE_WIDTH'(bus.push_ready_o), 1);

        // Single line with exact cycle timing; cycle 0 is the push cycle.
        tick();
        push_line(A1, {4{32'h1111_2222}});
        @(negedge clk);
        cmp("c1_req", LINE_WIDTH'(bus.mem_req_o), 0);
        tick();
        @(negedge clk);
        cmp("c2_req", LINE_WIDTH'(bus.mem_req_o), 1);
        tick();
        tick();
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        cmp("c5_req", LINE_WIDTH'(bus.mem_req_o), 0);
        tick();
        bus.mem_done_i = 1'b1;
        @(negedge clk);
        cmp("c6_hit_inflight", LINE_WIDTH'(bus.lookup_hit_o), 1);
        tick();
        bus.mem_done_i = 1'b0;
        @(negedge clk);
        cmp("c7_count", LINE_WIDTH'(bus.count_o), 0);
        cmp("c7_empty", LINE_WIDTH'(bus.empty_o), 1);
        cmp("c7_hit",   LINE_WIDTH'(bus.lookup_hit_o), 0);

        // Full and back-pressure.
        tick();
        push_line(34'h0_0000_1000, {4{32'hB1B1_0001}});
        push_line(34'h0_0000_2000, {4{32'hB2B2_0002}});
        @(negedge clk);
        cmp("full_count", LINE_WIDTH'(bus.count_o), 2);
        cmp("full_ready", LINE_WIDTH'(bus.push_ready_o), 0);
        tick();
        bus.push_valid_i = 1'b1;
        bus.push_addr_i  = 34'h0_0000_3000;
        bus.push_data_i  = {4{32'hCCCC_0003}};
        tick();
        tick();
        tick();
        @(negedge clk);
        cmp("bp_count", LINE_WIDTH'(bus.count_o), 2);
        cmp("bp_ready", LINE_WIDTH'(bus.push_ready_o), 0);
        tick();
        bus.push_valid_i = 1'b0;
        ack_req();
        finish_done();
        ack_req();
        finish_done();
        @(negedge clk);
        cmp("bp_drained", LINE_WIDTH'(bus.count_o), 0);

        // Push in the same cycle as the head's done.
        tick();
        push_line(34'h0_0000_5000, {4{32'hE1E1_0005}});
        ack_req();
        bus.mem_done_i   = 1'b1;
        bus.push_valid_i = 1'b1;
        bus.push_addr_i  = 34'h0_0000_6008;
        bus.push_data_i  = {4{32'hE2E2_0006}};
        exp_q.push_back('{addr: 34'h0_0000_6000, data: {4{32'hE2E2_0006}}});
        tick();
        bus.mem_done_i   = 1'b0;
        bus.push_valid_i = 1'b0;
        @(negedge clk);
        cmp("pp_count", LINE_WIDTH'(bus.count_o), 1);
        tick();
        ack_req();
        finish_done();
        @(negedge clk);
        cmp("pp_drained", LINE_WIDTH'(bus.count_o), 0);

        // Lookup with two entries for the same line; the youngest must win.
        tick();
        push_line(AL, DAA);
        push_line(AL + 34'h8, DBB);
        ack_req();
        bus.lookup_addr_i = AL + 34'h3;
        @(negedge clk);
        cmp("lk_hit",  LINE_WIDTH'(bus.lookup_hit_o), 1);
        cmp("lk_data", bus.lookup_data_o, FWD_BB);
        tick();
        bus.lookup_addr_i = AL + 34'h10;
        @(negedge clk);
        cmp("lk_miss_hit",  LINE_WIDTH'(bus.lookup_hit_o), 0);
        cmp("lk_miss_data", bus.lookup_data_o, 0);
        tick();
        finish_done();
        bus.lookup_addr_i = AL;
        @(negedge clk);
        cmp("lk_after_pop_hit",  LINE_WIDTH'(bus.lookup_hit_o), 1);
        cmp("lk_after_pop_data", bus.lookup_data_o, FWD_BB);
        tick();
        ack_req();
        finish_done();
        @(negedge clk);
        cmp("lk_drained_hit", LINE_WIDTH'(bus.lookup_hit_o), 0);

        // Spurious done in REQ and spurious ack in WAIT_DONE.
        tick();
        push_line(34'h0_0000_7000, {4{32'hF0F0_0007}});
        wait_req();
        bus.mem_done_i = 1'b1;
        tick();
        bus.mem_done_i = 1'b0;
        @(negedge clk);
        cmp("sp_done_req",   LINE_WIDTH'(bus.mem_req_o), 1);
        cmp("sp_done_count", LINE_WIDTH'(bus.count_o), 1);
        tick();
        ack_req();
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        cmp("sp_ack_req",   LINE_WIDTH'(bus.mem_req_o), 0);
        cmp("sp_ack_count", LINE_WIDTH'(bus.count_o), 1);
        tick();
        @(negedge clk);
        cmp("sp_ack_req2", LINE_WIDTH'(bus.mem_req_o), 0);
        tick();
        finish_done();
        @(negedge clk);
        cmp("sp_drained", LINE_WIDTH'(bus.count_o), 0);

        // Reset while the head write is in flight with a second line queued.
        tick();
        push_line(34'h0_0000_8000, {4{32'h6161_0008}});
        push_line(34'h0_0000_9000, {4{32'h6262_0009}});
        ack_req();
        @(negedge clk);
        cmp("mr_count_pre", LINE_WIDTH'(bus.count_o), 2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        bus.lookup_addr_i = 34'h0_0000_8000;
        @(negedge clk);
        cmp("mr_count", LINE_WIDTH'(bus.count_o), 0);
        cmp("mr_req",   LINE_WIDTH'(bus.mem_req_o), 0);
        cmp("mr_hit",   LINE_WIDTH'(bus.lookup_hit_o), 0);
        cmp("mr_empty", LINE_WIDTH'(bus.empty_o), 1);
        tick();
        finish_done();
        @(negedge clk);
        cmp("mr_late_done_count", LINE_WIDTH'(bus.count_o), 0);
        tick();
        tick();
        tick();
        @(negedge clk);
        cmp("mr_late_req", LINE_WIDTH'(bus.mem_req_o), 0);

        cmp("sb_drained", LINE_WIDTH'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
